ov7670_capture: RTL and testbench

OV7670_CAPTURE -- requirements
Module: ov7670_capture

---
 rtl/ov7670_capture.sv | 231 +++++++++++++++++++++++
 tb/tb_ov7670_capture.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_capture.sv
// ov7670_capture
// Captures RGB565 pixels from an OV7670-style parallel camera bus into
// frame-buffer write strobes. Every camera signal is treated as asynchronous
// data and sampled on in_clk. pclk/vsync/href edges are detected after a
// two-stage synchronizer.
//
// Ports
//   in_clk      system clock (only clock)
//   rst_n       asynchronous active-low reset
//   enable      arm capture of the next frame
//   cam_pclk    camera pixel clock (sampled as data)
//   cam_vsync   camera frame sync, high between frames
//   cam_href    camera line valid
//   cam_data    camera byte bus
//   pix_data    assembled RGB565 pixel
//   pix_valid   one-cycle strobe qualifying pix_data/pix_addr
//   pix_addr    frame-buffer write address (row*H_PIXELS+col)
//   frame_done  one-cycle pulse when a captured frame ends
//   busy        high while waiting for a frame or capturing one
module ov7670_capture #(
  parameter int H_PIXELS = 320,
  parameter int V_LINES  = 240,
  parameter int ADDR_W   = 17
) (
  input  logic              in_clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic [15:0]       pix_data,
  output logic              pix_valid,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              frame_done,
  output logic              busy
);

  localparam int COL_W = $clog2(H_PIXELS + 1);
  localparam int ROW_W = $clog2(V_LINES + 1);
  localparam logic [COL_W-1:0]  H_MAX  = COL_W'(H_PIXELS);
  localparam logic [ROW_W-1:0]  V_MAX  = ROW_W'(V_LINES);
  localparam logic [ROW_W-1:0]  V_LAST = ROW_W'(V_LINES - 1);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_PIXELS);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_VSYNC = 2'd1,
    CAPTURE    = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Bit 0 = stage 1, bit 1 = stage 2, bit 2 = delayed copy for edge detect.
  logic [2:0] pclk_q;
  logic [2:0] vsync_q;
  logic [2:0] href_q;
  logic [7:0] data_s1_q;
  logic [7:0] data_s2_q;

  logic              phase_q, phase_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        byte_hi_q, byte_hi_d;
  logic [15:0]       pix_data_q, pix_data_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  logic              pix_valid_q, pix_valid_d;
  logic              frame_done_q, frame_done_d;
  logic              busy_q, busy_d;

  logic pclk_rise;
  logic vs_rise;
  logic vs_fall;
  logic href_fall;
  logic href_s2;

  assign pclk_rise = pclk_q[1] & ~pclk_q[2];
  assign vs_rise   = vsync_q[1] & ~vsync_q[2];
  assign vs_fall   = ~vsync_q[1] & vsync_q[2];
  assign href_fall = ~href_q[1] & href_q[2];
  assign href_s2   = href_q[1];

  // Synchronizer chains; data only needs two stages since no edge is taken on it.
  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      pclk_q    <= 3'b000;
      vsync_q   <= 3'b000;
      href_q    <= 3'b000;
      data_s1_q <= 8'h00;
      data_s2_q <= 8'h00;
    end else begin
      pclk_q    <= {pclk_q[1:0], cam_pclk};
      vsync_q   <= {vsync_q[1:0], cam_vsync};
      href_q    <= {href_q[1:0], cam_href};
      data_s1_q <= cam_data;
      data_s2_q <= data_s1_q;
    end
  end

  // Next-state and datapath decode for the capture FSM.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    col_d        = col_q;
    row_d        = row_q;
    row_base_d   = row_base_q;
    wr_addr_d    = wr_addr_q;
    byte_hi_d    = byte_hi_q;
    pix_data_d   = pix_data_q;
    pix_addr_d   = pix_addr_q;
    pix_valid_d  = 1'b0;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = WAIT_VSYNC;
        end else begin
          state_d = IDLE;
        end
      end

      WAIT_VSYNC: begin
        if (vs_fall) begin
          state_d    = CAPTURE;
          phase_d    = 1'b0;
          col_d      = '0;
          row_d      = '0;
          row_base_d = '0;
          wr_addr_d  = '0;
        end else begin
          state_d = WAIT_VSYNC;
        end
      end

      CAPTURE: begin
        if (vs_rise) begin
          // Frame end wins over any byte; a half-assembled pixel is dropped.
          state_d      = IDLE;
          frame_done_d = 1'b1;
          phase_d      = 1'b0;
        end else if (href_fall) begin
          phase_d = 1'b0;
          col_d   = '0;
          if (row_q < V_MAX) begin
            row_d = row_q + ROW_W'(1);
          end else begin
            row_d = row_q;
          end
          // Base only advances while a next stored row exists, so it never wraps.
          if (row_q < V_LAST) begin
            row_base_d = row_base_q + H_STEP;
            wr_addr_d  = row_base_q + H_STEP;
          end else begin
            row_base_d = row_base_q;
            wr_addr_d  = row_base_q;
          end
        end else if (pclk_rise && href_s2) begin
          if (!phase_q) begin
            byte_hi_d = data_s2_q;
            phase_d   = 1'b1;
          end else begin
            phase_d = 1'b0;
            // col saturates at H_PIXELS: everything past it is dropped anyway.
            if (col_q < H_MAX) begin
              col_d = col_q + COL_W'(1);
            end else begin
              col_d = col_q;
            end
            if ((col_q < H_MAX) && (row_q < V_MAX)) begin
              pix_valid_d = 1'b1;
              pix_data_d  = {byte_hi_q, data_s2_q};
              pix_addr_d  = wr_addr_q;
              wr_addr_d   = wr_addr_q + ADDR_W'(1);
            end else begin
              pix_valid_d = 1'b0;
            end
          end
        end else begin
          state_d = CAPTURE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      phase_q      <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      row_base_q   <= '0;
      wr_addr_q    <= '0;
      byte_hi_q    <= 8'h00;
      pix_data_q   <= 16'h0000;
      pix_addr_q   <= '0;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      col_q        <= col_d;
      row_q        <= row_d;
      row_base_q   <= row_base_d;
      wr_addr_q    <= wr_addr_d;
      byte_hi_q    <= byte_hi_d;
      pix_data_q   <= pix_data_d;
      pix_addr_q   <= pix_addr_d;
      pix_valid_q  <= pix_valid_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign pix_data   = pix_data_q;
  assign pix_addr   = pix_addr_q;
  assign pix_valid  = pix_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// Scoreboard bench for ov7670_capture with a 4x2 frame. The stimulus side
// computes each expected pixel (address, data, arrival cycle) from the line
// byte lists and pushes it; a monitor pops and compares on every pix_valid.
module tb_ov7670_capture;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int AW = 3;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    logic [31:0]   cyc;
  } exp_t;

  logic          in_clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          cam_pclk;
  logic          cam_vsync;
  logic          cam_href;
  logic [7:0]    cam_data;
  logic [15:0]   pix_data;
  logic          pix_valid;
  logic [AW-1:0] pix_addr;
  logic          frame_done;
  logic          busy;

  ov7670_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
    .in_clk(in_clk), .rst_n(rst_n), .enable(enable), .cam_pclk(cam_pclk),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_addr(pix_addr),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 in_clk = ~in_clk;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         fd_count = 0;
  int         fd_exp = 0;
  bit         fd_prev = 1'b0;
  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] lb[$];
  // Reference model: armed = waiting for a vsync fall, capturing = in a frame.
  bit         armed = 1'b0;
  bit         capturing = 1'b0;
  int         m_row = 0;
  int         half = 3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each strobe and checks frame_done width.
  always begin
    @(posedge in_clk);
    cyc++;
    #1;
    if (pix_valid) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pixel: got addr=%0d data=%h, expected no strobe", pix_addr, pix_data);
      end else begin
        mon_e = sb.pop_front();
        if (pix_addr !== mon_e.addr || pix_data !== mon_e.data || cyc !== int'(mon_e.cyc)) begin
          failures++;
          $display("FAIL pixel: got addr=%0d data=%h cyc=%0d expected addr=%0d data=%h cyc=%0d",
                   pix_addr, pix_data, cyc, mon_e.addr, mon_e.data, mon_e.cyc);
        end
      end
    end
    if (frame_done) begin
      fd_count++;
      checks++;
      if (fd_prev) begin
        failures++;
        $display("FAIL frame_done_width: got 2+ cycles expected 1");
      end
    end
    fd_prev = frame_done;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge in_clk);
  endtask

  task automatic set_enable(input bit v);
    @(negedge in_clk);
    enable = v;
    if (v && !capturing) armed = 1'b1;
  endtask

  task automatic frame_start();
    @(negedge in_clk);
    cam_vsync = 1'b0;
    if (armed) begin
      capturing = 1'b1;
      armed = 1'b0;
      m_row = 0;
    end
    tick(4);
  endtask

  task automatic frame_end();
    @(negedge in_clk);
    cam_vsync = 1'b1;
    if (capturing) begin
      capturing = 1'b0;
      fd_exp++;
      armed = enable;
    end
    tick(6);
  endtask

  // Drives lb[] with href high; pixel k = bytes 2k,2k+1 lands at row*H+k.
  task automatic send_bytes();
    exp_t e;
    @(negedge in_clk);
    cam_href = 1'b1;
    tick(half);
    foreach (lb[i]) begin
      cam_data = lb[i];
      cam_pclk = 1'b1;
      if (capturing && (i % 2 == 1) && (i / 2 < H) && (m_row < V)) begin
        e.addr = AW'(m_row * H + i / 2);
        e.data = {lb[i-1], lb[i]};
        e.cyc  = 32'(cyc + 3);
        sb.push_back(e);
      end
      tick(half);
      cam_pclk = 1'b0;
      tick(half);
    end
  endtask

  task automatic end_line();
    @(negedge in_clk);
    cam_href = 1'b0;
    if (capturing) m_row++;
    tick(3);
  endtask

  task automatic fill_seq(input int n, input logic [7:0] start);
    lb.delete();
    for (int i = 0; i < n; i++) lb.push_back(start + 8'(i) * 8'h22);
  endtask

  task automatic fill_rand(input int n);
    lb.delete();
    for (int i = 0; i < n; i++) lb.push_back(8'($urandom));
  endtask

  task automatic line_seq(input int n, input logic [7:0] start);
    fill_seq(n, start);
    send_bytes();
    end_line();
  endtask

  task automatic frame_checks(input string tag);
    tick(4);
    check({tag, "_frame_done_count"}, 32'(fd_count), 32'(fd_exp));
    check({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; cam_pclk = 1'b0; cam_vsync = 1'b1;
    cam_href = 1'b0; cam_data = 8'h00;
    tick(3);
    check("reset_outputs", 32'({pix_data, pix_valid, pix_addr, frame_done, busy}), 32'd0);
    @(negedge in_clk);
    rst_n = 1'b1;
    tick(5);
    check("idle_busy", 32'(busy), 32'd0);
    set_enable(1'b1);
    tick(2);
    check("wait_busy", 32'(busy), 32'd1);

    // Basic frame: addresses 0..7, data 0x1234, 0x5678, ...
    frame_start();
    line_seq(8, 8'h12);
    line_seq(8, 8'h22);
    frame_end();
    frame_checks("basic");

    // Over-long line (fifth pixel dropped), next line at addr 4.
    frame_start();
    line_seq(10, 8'h05);
    line_seq(4, 8'h40);
    frame_end();
    frame_checks("long_line");

    // Short line with partial pixel, then a row beyond V_LINES.
    frame_start();
    line_seq(3, 8'h12);
    line_seq(4, 8'h61);
    line_seq(8, 8'h77);
    frame_end();
    frame_checks("short_line");

    // Vsync rises while href is still high mid-pixel.
    frame_start();
    line_seq(8, 8'h31);
    fill_seq(3, 8'h9a);
    send_bytes();
    frame_end();
    @(negedge in_clk);
    cam_href = 1'b0;
    frame_checks("vsync_href_high");

    // Enable dropped mid-frame: frame completes, then no further capture.
    frame_start();
    line_seq(8, 8'h0f);
    set_enable(1'b0);
    line_seq(8, 8'hc3);
    frame_end();
    tick(3);
    check("disabled_busy", 32'(busy), 32'd0);
    frame_start();
    line_seq(8, 8'h44);
    frame_end();
    frame_checks("disabled");

    // Reset mid-line: immediate zero outputs, no frame_done, fresh arming.
    set_enable(1'b1);
    frame_start();
    fill_seq(4, 8'h5a);
    send_bytes();
    tick(6);
    @(negedge in_clk);
    rst_n = 1'b0;
    enable = 1'b0;
    armed = 1'b0;
    capturing = 1'b0;
    #1;
    check("midline_reset_outputs", 32'({pix_data, pix_valid, pix_addr, frame_done, busy}), 32'd0);
    tick(3);
    rst_n = 1'b1;
    end_line();
    frame_end();
    frame_start();
    line_seq(8, 8'h13);
    set_enable(1'b1);
    line_seq(8, 8'h27);
    frame_end();
    frame_checks("after_reset");
    frame_start();
    line_seq(8, 8'h81);
    line_seq(8, 8'h92);
    frame_end();
    frame_checks("resumed");

    // Random frames at in_clk/pclk ratios of 4 and 6.
    for (int f = 0; f < 8; f++) begin
      half = int'($urandom_range(2, 3));
      frame_start();
      for (int l = 0; l < int'($urandom_range(1, 3)); l++) begin
        fill_rand(int'($urandom_range(0, 12)));
        send_bytes();
        end_line();
      end
      frame_end();
    end
    frame_checks("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
